// File: rtl/sat_pkg.sv
// ============================================================================
//  Module      : sat_pkg
//  Description : Shared definitions for the local-search SAT block: walk-FSM
//                state encoding and a constant-foldable ceiling-log2 helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package sat_pkg;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_init = 3'd1;
    localparam logic [2:0] c_st_eval = 3'd2;
    localparam logic [2:0] c_st_pick = 3'd3;
    localparam logic [2:0] c_st_flip = 3'd4;
    localparam logic [2:0] c_st_done = 3'd5;

    // Ceiling log2; clog2(1) == 0. Also used to size the PLA flip counter.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (((value - 1) >> i) != 0) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/random_sreg.sv
// ============================================================================
//  Module      : random_sreg
//  Description : Galois LFSR, right-shifting, advancing every cycle out of reset.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module random_sreg #(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED = WIDTH'(32'hACE1),
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(32'h8020_0003)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else begin
            r_state <= {1'b0, r_state[WIDTH-1:1]} ^ (r_state[0] ? TAPS : '0);
        end
    end

    assign o_state = r_state;

endmodule

`default_nettype wire

// File: rtl/walk_controller.sv
// ============================================================================
//  Module      : walk_controller
//  Description : Random-restart local-search sequencer driving the PLA inputs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module walk_controller
    import sat_pkg::*;
#(
    parameter int          N     = 3,
    parameter int          FLIPS = 8,
    parameter int          TRIES = 4,
    parameter logic [31:0] SEED  = 32'hACE1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      sat_in,
    output logic [N-1:0]              assignment,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic [clog2(FLIPS+1)-1:0] flips_used,
    output logic [clog2(TRIES+1)-1:0] tries_used
);

    localparam int FW = clog2(FLIPS + 1);
    localparam int TW = clog2(TRIES + 1);
    localparam int IW = (clog2(N) > 1) ? clog2(N) : 1;

    localparam logic [FW-1:0] c_flips_max = FW'(FLIPS);
    localparam logic [TW-1:0] c_tries_max = TW'(TRIES);
    localparam logic [IW:0]   c_n         = (IW + 1)'(N);
    localparam logic [N-1:0]  c_one       = N'(1);

    logic [2:0]    r_state;
    logic [N-1:0]  r_assign;
    logic [IW-1:0] r_idx;
    logic [FW-1:0] r_flips;
    logic [TW-1:0] r_tries;
    logic          r_found;
    logic [31:0]   w_lfsr;
    logic [IW-1:0] w_pick_idx;
    logic          w_idx_ok;

    random_sreg #(
        .WIDTH (32),
        .SEED  (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (reset),
        .o_state (w_lfsr)
    );

    // Only the low LFSR bits feed the walk; the rest are intentionally dropped.
    if (N < 32) begin : g_unused
        logic w_unused_lfsr;
        assign w_unused_lfsr = ^w_lfsr[31:N];
    end

    assign w_pick_idx = w_lfsr[IW-1:0];
    assign w_idx_ok   = ({1'b0, w_pick_idx} < c_n);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_assign <= '0;
            r_idx    <= '0;
            r_flips  <= '0;
            r_tries  <= '0;
            r_found  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_tries <= '0;
                        r_state <= c_st_init;
                    end
                end
                c_st_init: begin
                    r_assign <= w_lfsr[N-1:0];
                    r_flips  <= '0;
                    r_tries  <= r_tries + TW'(1);
                    r_state  <= c_st_eval;
                end
                c_st_eval: begin
                    if (sat_in) begin
                        r_found <= 1'b1;
                        r_state <= c_st_done;
                    end else if ((r_flips == c_flips_max) && (r_tries == c_tries_max)) begin
                        r_found <= 1'b0;
                        r_state <= c_st_done;
                    end else if (r_flips == c_flips_max) begin
                        r_state <= c_st_init;
                    end else begin
                        r_state <= c_st_pick;
                    end
                end
                c_st_pick: begin
                    // Out-of-range indices are rejected and redrawn next cycle.
                    if (w_idx_ok) begin
                        r_idx   <= w_pick_idx;
                        r_state <= c_st_flip;
                    end
                end
                c_st_flip: begin
                    r_assign <= r_assign ^ (c_one << r_idx);
                    r_flips  <= r_flips + FW'(1);
                    r_state  <= c_st_eval;
                end
                c_st_done: begin
                    if (start) begin
                        r_tries <= '0;
                        r_found <= 1'b0;
                        r_state <= c_st_init;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign assignment = r_assign;
    assign busy       = (r_state == c_st_init) || (r_state == c_st_eval) ||
                        (r_state == c_st_pick) || (r_state == c_st_flip);
    assign done       = (r_state == c_st_done);
    assign found      = r_found;
    assign flips_used = r_flips;
    assign tries_used = r_tries;

endmodule

`default_nettype wire

// File: tb/tb_walk_controller.sv
// ============================================================================
//  Module      : tb_walk_controller
//  Description : Directed bench for walk_controller across three configurations.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_walk_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a, start_b, start_c;
    logic sat_a, sat_b, sat_c;

    // Instance A: N=4, FLIPS=4, TRIES=2
    logic [3:0] asg_a;
    logic       busy_a, done_a, found_a;
    logic [2:0] flips_a;
    logic [1:0] tries_a;

    // Instance B: N=4, FLIPS=15, TRIES=15, target 1010
    logic [3:0] asg_b;
    logic       busy_b, done_b, found_b;
    logic [3:0] flips_b;
    logic [3:0] tries_b;

    // Instance C: N=3 defaults, never satisfied
    logic [2:0] asg_c;
    logic       busy_c, done_c, found_c;
    logic [3:0] flips_c;
    logic [2:0] tries_c;

    assign sat_b = (asg_b == 4'b1010);
    assign sat_c = 1'b0;

    walk_controller #(.N(4), .FLIPS(4), .TRIES(2), .SEED(32'hACE1)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sat_in(sat_a),
        .assignment(asg_a), .busy(busy_a), .done(done_a), .found(found_a),
        .flips_used(flips_a), .tries_used(tries_a)
    );

    walk_controller #(.N(4), .FLIPS(15), .TRIES(15), .SEED(32'h1234_5678)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sat_in(sat_b),
        .assignment(asg_b), .busy(busy_b), .done(done_b), .found(found_b),
        .flips_used(flips_b), .tries_used(tries_b)
    );

    walk_controller #(.N(3), .FLIPS(8), .TRIES(4), .SEED(32'hACE1)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_c), .sat_in(sat_c),
        .assignment(asg_c), .busy(busy_c), .done(done_c), .found(found_c),
        .flips_used(flips_c), .tries_used(tries_c)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        int scen;
        int k;
        int busy;
        int done;
        int found;
        int flips;
        int tries;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    // Pulse start on instance A, then sample #1 after each edge k (k=0 is the
    // edge that samples start) and compare against every table row for scen.
    task automatic run_seq(input int scen, input logic sat_val, input bit pulse_mid, input int kmax);
        sat_a   = sat_val;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        for (int k = 0; k <= kmax; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            for (int v = 0; v < NV; v++) begin
                if (vecs[v].scen == scen && vecs[v].k == k) begin
                    check($sformatf("s%0d_k%0d_busy", scen, k),  int'(busy_a),  vecs[v].busy);
                    check($sformatf("s%0d_k%0d_done", scen, k),  int'(done_a),  vecs[v].done);
                    check($sformatf("s%0d_k%0d_found", scen, k), int'(found_a), vecs[v].found);
                    check($sformatf("s%0d_k%0d_flips", scen, k), int'(flips_a), vecs[v].flips);
                    check($sformatf("s%0d_k%0d_tries", scen, k), int'(tries_a), vecs[v].tries);
                end
            end
            start_a = pulse_mid && (k == 1 || k == 2);
        end
        start_a = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int    cyc;
        int    bad;
        int    prev_flips;
        logic [2:0] prev_asg;

        //                scen k  busy done found flips tries
        // Scenario 0: sat tied 0 from reset, two full tries of 14 cycles each.
        vecs[0]  = '{0,  0, 1, 0, 0, 0, 0};
        vecs[1]  = '{0,  1, 1, 0, 0, 0, 1};
        vecs[2]  = '{0,  2, 1, 0, 0, 0, 1};
        vecs[3]  = '{0,  3, 1, 0, 0, 0, 1};
        vecs[4]  = '{0,  4, 1, 0, 0, 1, 1};
        vecs[5]  = '{0, 13, 1, 0, 0, 4, 1};
        vecs[6]  = '{0, 14, 1, 0, 0, 4, 1};
        vecs[7]  = '{0, 15, 1, 0, 0, 0, 2};
        vecs[8]  = '{0, 27, 1, 0, 0, 4, 2};
        vecs[9]  = '{0, 28, 0, 1, 0, 4, 2};
        vecs[10] = '{0, 35, 0, 1, 0, 4, 2};
        // Scenario 1: sat tied 1, done two cycles after start.
        vecs[11] = '{1,  0, 1, 0, 0, 0, 0};
        vecs[12] = '{1,  1, 1, 0, 0, 0, 1};
        vecs[13] = '{1,  2, 0, 1, 1, 0, 1};
        vecs[14] = '{1, 10, 0, 1, 1, 0, 1};
        // Scenario 2: restart from DONE(found=1), sat 0, start pulsed in EVAL/PICK.
        vecs[15] = '{2,  0, 1, 0, 0, 0, 0};
        vecs[16] = '{2,  1, 1, 0, 0, 0, 1};
        vecs[17] = '{2,  3, 1, 0, 0, 0, 1};
        vecs[18] = '{2,  4, 1, 0, 0, 1, 1};
        vecs[19] = '{2, 15, 1, 0, 0, 0, 2};
        vecs[20] = '{2, 27, 1, 0, 0, 4, 2};
        vecs[21] = '{2, 28, 0, 1, 0, 4, 2};

        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        sat_a   = 1'b0;
        do_reset();

        check("rst_asg",   int'(asg_a),   0);
        check("rst_busy",  int'(busy_a),  0);
        check("rst_done",  int'(done_a),  0);
        check("rst_found", int'(found_a), 0);
        check("rst_flips", int'(flips_a), 0);
        check("rst_tries", int'(tries_a), 0);

        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start_busy", int'(busy_a), 0);

        run_seq(0, 1'b0, 1'b0, 35);
        do_reset();
        run_seq(1, 1'b1, 1'b0, 10);
        run_seq(2, 1'b0, 1'b1, 28);

        // Mid-run reset: asynchronous clear, then held for two cycles.
        sat_a   = 1'b0;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrun_busy_before", int'(busy_a),  1);
        check("midrun_tries_before", int'(tries_a), 1);
        reset = 1'b1;
        #1;
        check("async_busy",  int'(busy_a),  0);
        check("async_flips", int'(flips_a), 0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_asg",   int'(asg_a),   0);
        check("midrst_busy",  int'(busy_a),  0);
        check("midrst_done",  int'(done_a),  0);
        check("midrst_found", int'(found_a), 0);
        check("midrst_flips", int'(flips_a), 0);
        check("midrst_tries", int'(tries_a), 0);
        reset = 1'b0;

        // Search for a specific target assignment.
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("target_timeout", int'(cyc < 2000), 1);
        check("target_found",   int'(found_b), 1);
        check("target_asg",     int'(asg_b),   4'b1010);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (asg_b != 4'b1010 || !done_b || !found_b) bad++;
        end
        check("target_hold", bad, 0);

        // N=3: rejections in PICK, every flip changes exactly one bit.
        start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0;
        cyc        = 0;
        bad        = 0;
        prev_flips = int'(flips_c);
        prev_asg   = asg_c;
        while (!done_c && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (int'(flips_c) == prev_flips + 1) begin
                if ($countones(asg_c ^ prev_asg) != 1) bad++;
            end else if (asg_c != prev_asg && flips_c != 0) begin
                bad++;
            end
            prev_flips = int'(flips_c);
            prev_asg   = asg_c;
        end
        check("n3_timeout",    int'(cyc < 1000), 1);
        check("n3_single_bit", bad, 0);
        check("n3_rejected",   int'(cyc > 104), 1);
        check("n3_found",      int'(found_c), 0);
        check("n3_flips",      int'(flips_c), 8);
        check("n3_tries",      int'(tries_c), 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
